hv_wdg_reg_scan: RTL and testbench



---
 rtl/hv_wdg_reg_scan.sv | 218 +++++++++++++++++++++
 tb/tb_hv_wdg_reg_scan.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hv_wdg_reg_scan.sv
// hv_wdg_reg_scan
// Watchdog register-scan sequencer. Sweeps a fixed register address window
// through the access controller's watchdog read port, one read at a time.
// Each returned word is checked against its stored CRC-8 (poly 0x07, init
// 0xFF, MSB first, no final XOR). CRC mismatches and missing acknowledges
// are counted and reported, and the end of every sweep is flagged.
module hv_wdg_reg_scan #(
  parameter int                REG_AW          = 7,
  parameter int                REG_DW          = 8,
  parameter int                REG_CRC_W       = 8,
  parameter logic [REG_AW-1:0] SCAN_START_ADDR = 7'h00,
  parameter logic [REG_AW-1:0] SCAN_END_ADDR   = 7'h3F,
  parameter int                SCAN_INTV_CYC   = 1000,
  parameter int                ACK_TO_CYC      = 64,
  parameter int                ERR_CNT_W       = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_scan_en,
  input  logic                 i_err_clr,
  output logic                 o_wdg_scan_rac_rd_req,
  output logic [REG_AW-1:0]    o_wdg_scan_rac_addr,
  input  logic                 i_rac_wdg_scan_ack,
  input  logic [REG_DW-1:0]    i_rac_wdg_scan_data,
  input  logic [REG_CRC_W-1:0] i_rac_wdg_scan_crc,
  output logic                 o_scan_busy,
  output logic                 o_scan_done,
  output logic                 o_scan_crc_err,
  output logic                 o_scan_timeout,
  output logic [REG_AW-1:0]    o_scan_err_addr,
  output logic                 o_scan_err_sticky,
  output logic [ERR_CNT_W-1:0] o_scan_err_cnt
);

  // Ack timeout counter counts the REQ cycles already spent (0..ACK_TO_CYC-1).
  localparam int TO_CNT_W = $clog2(ACK_TO_CYC);
  localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(ACK_TO_CYC - 1);

  // Gap counter counts idle cycles between sweeps (0..SCAN_INTV_CYC-1).
  localparam int GAP_CNT_W = (SCAN_INTV_CYC > 1) ? $clog2(SCAN_INTV_CYC) : 1;
  localparam logic [GAP_CNT_W-1:0] GAP_LAST =
    GAP_CNT_W'((SCAN_INTV_CYC > 0) ? SCAN_INTV_CYC - 1 : 0);

  localparam logic [REG_CRC_W-1:0] CRC_POLY = REG_CRC_W'(8'h07);
  localparam logic [REG_CRC_W-1:0] CRC_INIT = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    CHECK = 2'd2,
    GAP   = 2'd3
  } state_e;

  // Bit-serial CRC over one data word, MSB first.
  function automatic logic [REG_CRC_W-1:0] crc8_calc(input logic [REG_DW-1:0] data);
    logic [REG_CRC_W-1:0] crc;
    logic                 fb;
    crc = CRC_INIT;
    for (int i = REG_DW - 1; i >= 0; i--) begin
      fb  = crc[REG_CRC_W-1] ^ data[i];
      crc = {crc[REG_CRC_W-2:0], 1'b0};
      if (fb) crc = crc ^ CRC_POLY;
    end
    return crc;
  endfunction

  state_e                 state_q,    state_d;
  logic [REG_AW-1:0]      addr_q,     addr_d;
  logic [TO_CNT_W-1:0]    to_cnt_q,   to_cnt_d;
  logic [GAP_CNT_W-1:0]   gap_cnt_q,  gap_cnt_d;
  logic                   to_flag_q,  to_flag_d;
  logic [REG_DW-1:0]      data_q;
  logic [REG_CRC_W-1:0]   crc_q;
  logic                   cap_en;
  logic                   done_q,     done_d;
  logic                   crc_err_q,  crc_err_d;
  logic                   timeout_q,  timeout_d;
  logic                   err_evt;
  logic [REG_AW-1:0]      err_addr_q;
  logic                   sticky_q,   sticky_d;
  logic [ERR_CNT_W-1:0]   cnt_q,      cnt_d;
  logic                   crc_bad;

  assign crc_bad = (crc8_calc(data_q) != crc_q);

  // Next-state, address sequencing, counters and error bookkeeping.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d   = state_q;
    addr_d    = addr_q;
    to_cnt_d  = '0;
    gap_cnt_d = '0;
    to_flag_d = to_flag_q;
    cap_en    = 1'b0;
    done_d    = 1'b0;
    crc_err_d = 1'b0;
    timeout_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        addr_d = SCAN_START_ADDR;
        if (i_scan_en) state_d = REQ;
      end

      REQ: begin
        // Ack wins over a timeout landing in the same cycle. Scan enable is
        // deliberately not looked at: an issued access always completes.
        if (i_rac_wdg_scan_ack) begin
          cap_en    = 1'b1;
          to_flag_d = 1'b0;
          state_d   = CHECK;
        end else if (to_cnt_q == TO_LAST) begin
          to_flag_d = 1'b1;
          state_d   = CHECK;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end

      CHECK: begin
        // A timed-out access passes through here too, without a CRC verdict.
        timeout_d = to_flag_q;
        crc_err_d = !to_flag_q && crc_bad;
        if (!i_scan_en) begin
          addr_d  = SCAN_START_ADDR;
          state_d = IDLE;
        end else if (addr_q == SCAN_END_ADDR) begin
          done_d  = 1'b1;
          addr_d  = SCAN_START_ADDR;
          state_d = (SCAN_INTV_CYC == 0) ? REQ : GAP;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = REQ;
        end
      end

      GAP: begin
        if (!i_scan_en) begin
          addr_d  = SCAN_START_ADDR;
          state_d = IDLE;
        end else if (gap_cnt_q == GAP_LAST) begin
          state_d = REQ;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end

      default: begin
        addr_d  = SCAN_START_ADDR;
        state_d = IDLE;
      end
    endcase

    // Clear is applied first, then a coincident error is counted on top.
    err_evt  = crc_err_d | timeout_d;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    if (i_err_clr) begin
      cnt_d    = '0;
      sticky_d = 1'b0;
    end
    if (err_evt) begin
      sticky_d = 1'b1;
      if (cnt_d != '1) cnt_d = cnt_d + 1'b1;
    end
  end

  // State, address, counters, captured read word and reported status.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      addr_q     <= SCAN_START_ADDR;
      to_cnt_q   <= '0;
      gap_cnt_q  <= '0;
      to_flag_q  <= 1'b0;
      data_q     <= '0;
      crc_q      <= '0;
      done_q     <= 1'b0;
      crc_err_q  <= 1'b0;
      timeout_q  <= 1'b0;
      err_addr_q <= '0;
      sticky_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register here samples the
      // pre-edge values computed above, independent of statement order.
      state_q   <= state_d;
      addr_q    <= addr_d;
      to_cnt_q  <= to_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      to_flag_q <= to_flag_d;
      if (cap_en) begin
        data_q <= i_rac_wdg_scan_data;
        crc_q  <= i_rac_wdg_scan_crc;
      end
      done_q    <= done_d;
      crc_err_q <= crc_err_d;
      timeout_q <= timeout_d;
      if (err_evt) err_addr_q <= addr_q;
      sticky_q  <= sticky_d;
      cnt_q     <= cnt_d;
    end
  end

  // Request is decoded straight from the state register, so it drops in the
  // cycle after an ack and clears together with the asynchronous reset.
  assign o_wdg_scan_rac_rd_req = (state_q == REQ);
  assign o_wdg_scan_rac_addr   = addr_q;
  assign o_scan_busy           = (state_q != IDLE);
  assign o_scan_done           = done_q;
  assign o_scan_crc_err        = crc_err_q;
  assign o_scan_timeout        = timeout_q;
  assign o_scan_err_addr       = err_addr_q;
  assign o_scan_err_sticky     = sticky_q;
  assign o_scan_err_cnt        = cnt_q;

endmodule

// File: tb/tb_hv_wdg_reg_scan.sv
// tb_hv_wdg_reg_scan
// Directed bench for the watchdog register-scan sequencer. Window 0x00..0x02,
// 4-cycle inter-sweep gap, 64-cycle ack timeout, 8-bit error counter.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_hv_wdg_reg_scan;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scan_en;
  logic       err_clr;
  logic       ack;
  logic [7:0] rdata;
  logic [7:0] rcrc;

  logic       rd_req;
  logic [6:0] addr;
  logic       busy;
  logic       done;
  logic       crc_err;
  logic       timeout;
  logic [6:0] err_addr;
  logic       sticky;
  logic [7:0] cnt;

  int n_chk  = 0;
  int n_fail = 0;

  hv_wdg_reg_scan #(
    .REG_AW          (7),
    .REG_DW          (8),
    .REG_CRC_W       (8),
    .SCAN_START_ADDR (7'h00),
    .SCAN_END_ADDR   (7'h02),
    .SCAN_INTV_CYC   (4),
    .ACK_TO_CYC      (64),
    .ERR_CNT_W       (8)
  ) dut (
    .i_clk                 (clk),
    .i_rst_n               (rst_n),
    .i_scan_en             (scan_en),
    .i_err_clr             (err_clr),
    .o_wdg_scan_rac_rd_req (rd_req),
    .o_wdg_scan_rac_addr   (addr),
    .i_rac_wdg_scan_ack    (ack),
    .i_rac_wdg_scan_data   (rdata),
    .i_rac_wdg_scan_crc    (rcrc),
    .o_scan_busy           (busy),
    .o_scan_done           (done),
    .o_scan_crc_err        (crc_err),
    .o_scan_timeout        (timeout),
    .o_scan_err_addr       (err_addr),
    .o_scan_err_sticky     (sticky),
    .o_scan_err_cnt        (cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Wait for a request, check its address, ack it dly cycles later with the
  // given word. Returns on the falling edge of the cycle after the ack.
  task automatic serve(input logic [6:0] exp_addr, input int dly,
                       input logic [7:0] d, input logic [7:0] c);
    int waited = 0;
    while (rd_req !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("req_wait", (waited < 200) ? 32'd1 : 32'd0, 32'd1);
    check("req_addr", addr, exp_addr);
    repeat (dly) @(negedge clk);
    ack   = 1'b1;
    rdata = d;
    rcrc  = c;
    @(negedge clk);
    ack   = 1'b0;
    rdata = 8'h00;
    rcrc  = 8'h00;
    check("req_drop_after_ack", rd_req, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int hi;
    rst_n   = 1'b0;
    scan_en = 1'b0;
    err_clr = 1'b0;
    ack     = 1'b0;
    rdata   = 8'h00;
    rcrc    = 8'h00;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_rd_req",   rd_req,   1'b0);
    check("rst_addr",     addr,     7'h00);
    check("rst_busy",     busy,     1'b0);
    check("rst_done",     done,     1'b0);
    check("rst_crc_err",  crc_err,  1'b0);
    check("rst_timeout",  timeout,  1'b0);
    check("rst_err_addr", err_addr, 7'h00);
    check("rst_sticky",   sticky,   1'b0);
    check("rst_cnt",      cnt,      8'h00);

    rst_n = 1'b1;
    @(negedge clk);
    check("idle_no_req", rd_req, 1'b0);

    // Sweep 1: all good, ack 3 cycles after each request
    scan_en = 1'b1;
    @(negedge clk);
    check("en_req_latency", rd_req, 1'b1);
    check("en_busy",        busy,   1'b1);
    serve(7'h00, 3, 8'h00, 8'hF3);
    @(negedge clk);
    check("s1_req1",      rd_req,  1'b1);
    check("s1_addr1",     addr,    7'h01);
    check("s1_no_err0",   crc_err, 1'b0);
    serve(7'h01, 3, 8'h00, 8'hF3);
    @(negedge clk);
    check("s1_addr2",     addr,    7'h02);
    serve(7'h02, 3, 8'h00, 8'hF3);
    @(negedge clk);
    check("s1_done",      done,    1'b1);
    check("s1_done_noreq", rd_req, 1'b0);
    check("s1_gap_busy",  busy,    1'b1);
    check("s1_addr_wrap", addr,    7'h00);
    check("s1_cnt",       cnt,     8'h00);
    check("s1_sticky",    sticky,  1'b0);
    @(negedge clk);
    check("s1_done_pulse", done,   1'b0);
    check("s1_gap_req_a",  rd_req, 1'b0);
    repeat (2) begin
      @(negedge clk);
      check("s1_gap_req_b", rd_req, 1'b0);
    end
    @(negedge clk);
    check("s1_next_req", rd_req, 1'b1);
    check("s1_next_addr", addr,  7'h00);

    // Sweep 2: CRC mismatch at 0x01, ack withheld at 0x02
    serve(7'h00, 3, 8'h00, 8'hF3);
    @(negedge clk);
    serve(7'h01, 3, 8'h00, 8'h00);
    @(negedge clk);
    check("s2_crc_err",   crc_err,  1'b1);
    check("s2_err_addr",  err_addr, 7'h01);
    check("s2_cnt",       cnt,      8'h01);
    check("s2_sticky",    sticky,   1'b1);
    check("s2_cont_req",  rd_req,   1'b1);
    check("s2_cont_addr", addr,     7'h02);
    @(negedge clk);
    check("s2_crc_pulse", crc_err,  1'b0);
    hi = 1;
    while (rd_req === 1'b1 && hi < 200) begin
      hi++;
      @(negedge clk);
    end
    check("to_req_hold_cycles", hi, 64);
    check("to_not_yet", timeout, 1'b0);
    @(negedge clk);
    check("to_pulse",    timeout,  1'b1);
    check("to_err_addr", err_addr, 7'h02);
    check("to_cnt",      cnt,      8'h02);
    check("to_done",     done,     1'b1);
    check("to_crc_err",  crc_err,  1'b0);
    @(negedge clk);
    check("to_pulse_end", timeout, 1'b0);
    check("to_done_end",  done,    1'b0);

    // 260 more errors: counter saturates
    for (int i = 0; i < 260; i++) begin
      serve(7'(i % 3), 0, 8'h00, 8'h00);
    end
    @(negedge clk);
    check("sat_cnt",    cnt,    8'hFF);
    check("sat_sticky", sticky, 1'b1);

    // Clear coinciding with an error at 0x02
    serve(7'h02, 0, 8'h00, 8'h00);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("clr_err_cnt",    cnt,      8'h01);
    check("clr_err_sticky", sticky,   1'b1);
    check("clr_err_addr",   err_addr, 7'h02);

    // Plain clear during the gap
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("clr_cnt",      cnt,      8'h00);
    check("clr_sticky",   sticky,   1'b0);
    check("clr_keep_addr", err_addr, 7'h02);

    // Good word 0xFF / 0x00, then drop enable while requesting 0x01
    serve(7'h00, 1, 8'hFF, 8'h00);
    @(negedge clk);
    check("ff_no_err", crc_err, 1'b0);
    check("ff_cnt",    cnt,     8'h00);
    check("ff_addr",   addr,    7'h01);
    scan_en = 1'b0;
    repeat (2) @(negedge clk);
    check("dis_req_held", rd_req, 1'b1);
    serve(7'h01, 0, 8'h00, 8'hF3);
    check("dis_check_busy", busy, 1'b1);
    @(negedge clk);
    check("dis_idle_busy", busy,   1'b0);
    check("dis_idle_req",  rd_req, 1'b0);
    check("dis_idle_addr", addr,   7'h00);
    check("dis_no_done",   done,   1'b0);
    ack   = 1'b1;
    rdata = 8'h00;
    rcrc  = 8'h00;
    @(negedge clk);
    ack   = 1'b0;
    @(negedge clk);
    check("spur_busy",    busy,    1'b0);
    check("spur_crc_err", crc_err, 1'b0);
    check("spur_cnt",     cnt,     8'h00);
    check("spur_req",     rd_req,  1'b0);

    // Reset in the middle of a request
    scan_en = 1'b1;
    @(negedge clk);
    check("rs_req", rd_req, 1'b1);
    serve(7'h00, 1, 8'h00, 8'hF3);
    @(negedge clk);
    serve(7'h01, 1, 8'h00, 8'h00);
    @(negedge clk);
    check("rs_pre_cnt",  cnt,    8'h01);
    check("rs_pre_req",  rd_req, 1'b1);
    check("rs_pre_addr", addr,   7'h02);
    #1 rst_n = 1'b0;
    #1;
    check("rs_async_req",  rd_req,   1'b0);
    check("rs_async_busy", busy,     1'b0);
    check("rs_async_addr", addr,     7'h00);
    check("rs_async_cnt",  cnt,      8'h00);
    check("rs_async_stk",  sticky,   1'b0);
    check("rs_async_eadr", err_addr, 7'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rs_restart_req",  rd_req, 1'b1);
    check("rs_restart_addr", addr,   7'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
